stream_crossbar_arbiter: RTL
============================

Name: stream_crossbar_arbiter

Overview:
- Registered N-input to M-output streaming crossbar with valid/ready handshakes.
- Each input carries a destination index and presents a word to that output.
- Each output runs an independent round-robin arbiter over the inputs contending for it, and holds the winner in a one-entry output register.
- Sits between initiator-side stream sources and the selected-path consumers. It returns backpressure toward the sources and resolves contention when several sources target one output.

Parameters:
- N_IN, 2, number of input ports (≥1)
- N_OUT, 2, number of output ports (≥1)
- WIDTH, 8, data width in bits
- DEST_W, max(1, clog2(N_OUT)), derived; width of destination index
- SRC_W, max(1, clog2(N_IN)), derived; width of source tag

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- io_in_valid  input  N_IN  per-input word valid
- io_in_ready  output  N_IN  per-input accept
- io_in_data  input  N_IN*WIDTH  packed input words; input i at bits [i*WIDTH +: WIDTH]
- io_in_dest  input  N_IN*DEST_W  packed destination index per input
- io_out_valid  output  N_OUT  output register holds a word
- io_out_ready  input  N_OUT  consumer accept per output
- io_out_data  output  N_OUT*WIDTH  packed output words
- io_out_src  output  N_OUT*SRC_W  index of the input that produced the held word
- io_drop  output  1  one-cycle pulse: a word with out-of-range destination was discarded

Behaviour:
- Reset, asynchronous and active-high, forces:
  - io_out_valid=0, io_out_data=0, io_out_src=0, io_drop=0
  - all round-robin pointers=0
  - io_in_ready is combinational and is 0 while any request is pending at reset.
- Reset asserted mid-transfer discards held words; no partial state survives.
- Request: input i requests output j when io_in_valid[i]=1 and dest_i==j.
- Space: output j has space when io_out_valid[j]=0, or when io_out_valid[j]=1 and io_out_ready[j]=1 in the same cycle. The latter is a pass-through refill that sustains 1 word/cycle/output.
- Arbitration, per output j, combinational:
  - Among requesting inputs, grant the first at or after ptr_j, scanning upward modulo N_IN.
  - Grant is issued only if output j has space.
- io_in_ready[i] = 1 iff input i is granted by its destination output.
  - At most one grant per input per cycle, since each input has a single destination.
  - io_in_ready must not depend on io_in_valid of the same input beyond the request term; no combinational loop through io_out_ready is permitted other than the space term.
- On grant (valid & ready on input i to output j), at the clock edge:
  - out_data_j <= data_i, out_src_j <= i, out_valid_j <= 1
  - ptr_j <= (i+1) mod N_IN
- Drain without refill: out_valid_j <= 0, and data/src hold their last values.
- No grant: ptr_j is unchanged. Pointers advance only on accepted transfers.
- Latency: an accepted input word appears on io_out_* the next cycle, fixed at 1 cycle.
- Held outputs are stable: io_out_data and io_out_src are constant while io_out_valid=1 and io_out_ready=0.
- Out-of-range destination (dest_i ≥ N_OUT, possible only when N_OUT is not a power of two):
  - io_in_ready[i]=1 unconditionally; the word is discarded.
  - io_drop is registered, pulsing high the cycle after any such acceptance.
  - No pointer changes.
- Simultaneous events:
  - Drain and refill on the same output in one cycle are both honoured.
  - Multiple requesters on one output: exactly one is granted and the others see ready=0.
  - Different outputs operate fully in parallel.
- Fairness: with continuous contention from k inputs, each is served once every k accepted words on that output.

Decomposition:
- Shared package holds the DEST_W/SRC_W derivation functions (clog2 with floor of 1) and the packed-slice index helpers.
- One natural sub-module, rr_arbiter:
  - Parameter N
  - Inputs: req[N], advance, granted index
  - Outputs: one-hot grant and index; holds its pointer internally
- Instantiate rr_arbiter N_OUT times with N=N_IN; the top module contains the request decode and output registers.

Test Plan:
- Reset mid-stream: assert reset while out0 holds 0xA5 -> io_out_valid=00 immediately (asynchronous), io_in_ready=0 during reset; after release, first accepted word appears with 1-cycle latency.
- Single path: in0 valid, dest=1, data=0x3C, out1_ready=1 -> in_ready[0]=1 that cycle; next cycle out_valid=10, out1_data=0x3C, out1_src=0.
- Contention fairness: in0 and in1 both dest=0 continuously, data 0x10.., 0x20.., out0_ready=1 -> out0_src sequence 0,1,0,1 (ptr starts 0), one word per cycle, no bubbles.
- Backpressure: out0 holds 0x55 with out0_ready=0 for 3 cycles while in1 requests dest 0 -> in_ready[1]=0 and out0_data stays 0x55; on ready=1, same-cycle refill, next cycle out0_data is in1's word.
- Parallel paths: in0->dest 1 (0x11), in1->dest 0 (0x22) same cycle -> both in_ready=1; next cycle out0_data=0x22/src=1 and out1_data=0x11/src=0.
- Drop (N_OUT=3): in0 dest=3, data 0xFF -> in_ready[0]=1, io_drop=1 next cycle for exactly one cycle, no out_valid change.

Source files
------------

// File: rtl/stream_crossbar_arbiter_pkg.sv
// Shared definitions for the streaming crossbar.
//   clog2_min1 : index width for a count, never narrower than one bit
//   slice_lo   : low bit of element idx inside a packed vector of w-bit elements
package stream_crossbar_arbiter_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/stream_crossbar_arbiter_rr_arbiter.sv
// Round-robin arbiter over N requesters with an internal rotating pointer.
// Ports:
//   clock, reset   : clock and asynchronous active-high reset (pointer -> 0)
//   i_req[N]       : request vector
//   i_advance      : a grant was accepted this cycle
//   i_gnt_idx      : index of the accepted requester; pointer moves past it
//   o_grant[N]     : one-hot grant (first requester at or after the pointer)
//   o_idx          : binary index of o_grant
//   o_any          : at least one requester present
module stream_crossbar_arbiter_rr_arbiter
  import stream_crossbar_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  input  logic [IW-1:0] i_gnt_idx,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;

  // Scan upward from the pointer, wrapping modulo N; first hit wins.
  always_comb begin : scan
    int p;
    p       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      p = int'(r_ptr) + k;
      if (p >= N) p = p - N;
      if (!o_any && i_req[p]) begin
        o_any      = 1'b1;
        o_grant[p] = 1'b1;
        o_idx      = IW'(p);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      if (int'(i_gnt_idx) >= N - 1) r_ptr <= '0;
      else                          r_ptr <= i_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/stream_crossbar_arbiter.sv
// Registered N_IN x N_OUT streaming crossbar with per-output round-robin
// arbitration and a one-entry output register per output.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   io_in_valid   : per-input valid             io_in_ready : per-input accept (combinational)
//   io_in_data    : packed input words           io_in_dest  : packed destination indices
//   io_out_valid  : output register occupied     io_out_ready: consumer accept per output
//   io_out_data   : packed held words            io_out_src  : packed source index of held word
//   io_drop       : one-cycle pulse after a word with out-of-range destination is discarded
module stream_crossbar_arbiter
  import stream_crossbar_arbiter_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 8,
  parameter int DEST_W = clog2_min1(N_OUT),
  parameter int SRC_W  = clog2_min1(N_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_IN-1:0]         io_in_valid,
  output logic [N_IN-1:0]         io_in_ready,
  input  logic [N_IN*WIDTH-1:0]   io_in_data,
  input  logic [N_IN*DEST_W-1:0]  io_in_dest,
  output logic [N_OUT-1:0]        io_out_valid,
  input  logic [N_OUT-1:0]        io_out_ready,
  output logic [N_OUT*WIDTH-1:0]  io_out_data,
  output logic [N_OUT*SRC_W-1:0]  io_out_src,
  output logic                    io_drop
);

  logic [DEST_W-1:0] w_dest     [N_IN];
  logic [N_IN-1:0]   w_in_range;
  logic [N_IN-1:0]   w_req      [N_OUT];
  logic [N_IN-1:0]   w_gnt      [N_OUT];
  logic [SRC_W-1:0]  w_gidx     [N_OUT];
  logic [N_OUT-1:0]  w_any;
  logic [N_OUT-1:0]  w_space;
  logic [N_OUT-1:0]  w_acc;
  logic [WIDTH-1:0]  w_sel_data [N_OUT];
  logic [N_IN-1:0]   w_in_ready;
  logic              w_drop_any;

  logic [N_OUT-1:0]  r_out_valid;
  logic [WIDTH-1:0]  r_out_data [N_OUT];
  logic [SRC_W-1:0]  r_out_src  [N_OUT];
  logic              r_drop;

  genvar gi, gj;

  // Destination decode per input.
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      assign w_dest[gi]     = io_in_dest[slice_lo(gi, DEST_W) +: DEST_W];
      assign w_in_range[gi] = int'(w_dest[gi]) < N_OUT;
    end
  endgenerate

  generate
    for (gj = 0; gj < N_OUT; gj++) begin : g_out
      for (gi = 0; gi < N_IN; gi++) begin : g_req
        assign w_req[gj][gi] = io_in_valid[gi] && (w_dest[gi] == DEST_W'(gj));
      end

      // Space includes the pass-through case so a draining output refills in the same cycle.
      assign w_space[gj] = !r_out_valid[gj] || io_out_ready[gj];
      assign w_acc[gj]   = w_any[gj] && w_space[gj];

      stream_crossbar_arbiter_rr_arbiter #(.N(N_IN)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .i_req     (w_req[gj]),
        .i_advance (w_acc[gj]),
        .i_gnt_idx (w_gidx[gj]),
        .o_grant   (w_gnt[gj]),
        .o_idx     (w_gidx[gj]),
        .o_any     (w_any[gj])
      );

      assign w_sel_data[gj] = io_in_data[slice_lo(int'(w_gidx[gj]), WIDTH) +: WIDTH];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_out_valid[gj] <= 1'b0;
          r_out_data[gj]  <= '0;
          r_out_src[gj]   <= '0;
        end else if (w_acc[gj]) begin
          r_out_valid[gj] <= 1'b1;
          r_out_data[gj]  <= w_sel_data[gj];
          r_out_src[gj]   <= w_gidx[gj];
        end else if (io_out_ready[gj]) begin
          // Drain without refill: data/src keep their last values.
          r_out_valid[gj] <= 1'b0;
        end
      end

      assign io_out_data[slice_lo(gj, WIDTH) +: WIDTH] = r_out_data[gj];
      assign io_out_src[slice_lo(gj, SRC_W) +: SRC_W]  = r_out_src[gj];
    end
  endgenerate

  // Ready comes from the grant of the input's own destination; out-of-range
  // destinations are always accepted (and discarded). Nothing is accepted in reset.
  always_comb begin
    w_in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (!w_in_range[i]) begin
        w_in_ready[i] = 1'b1;
      end else begin
        for (int j = 0; j < N_OUT; j++) begin
          if (int'(w_dest[i]) == j) w_in_ready[i] = w_gnt[j][i] && w_space[j];
        end
      end
    end
    if (reset) w_in_ready = '0;
  end

  assign w_drop_any = (|(io_in_valid & ~w_in_range)) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_drop <= 1'b0;
    else       r_drop <= w_drop_any;
  end

  assign io_in_ready  = w_in_ready;
  assign io_out_valid = r_out_valid;
  assign io_drop      = r_drop;

endmodule
